// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
//   Shared definitions for the frame-buffer address sequencer:
//     - default geometry and stride constants for a 320x240, 32-bpp frame store
//     - flip state enum (IDLE, PENDING)
//     - 2-bit buffer index type and the round-robin successor helper
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int unsigned DEF_ADDR_W          = 32;
    localparam int unsigned DEF_X_W             = 9;
    localparam int unsigned DEF_Y_W             = 8;
    localparam int unsigned DEF_H_RES           = 320;
    localparam int unsigned DEF_V_RES           = 240;
    localparam int unsigned DEF_BYTES_PER_PIXEL = 4;
    localparam int unsigned DEF_LINE_STRIDE     = 1280;
    localparam logic [31:0] DEF_BUF_STRIDE      = 32'h0004_B000;
    localparam logic [31:0] DEF_BASE_ADDR       = 32'h0000_0000;
    localparam int unsigned DEF_NUM_BUFS        = 2;

    typedef enum logic {
        IDLE,
        PENDING
    } flip_state_e;

    typedef logic [1:0] buf_idx_t;

    // Next buffer in round-robin order; wraps at num_bufs, so with two
    // buffers it simply toggles between 0 and 1.
    function automatic buf_idx_t next_buf(input buf_idx_t idx, input int unsigned num_bufs);
        if (32'(idx) + 32'd1 >= num_bufs) begin
            return '0;
        end
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// -----------------------------------------------------------------------------
// fb_addr_calc
//   One coordinate-to-byte-address path with range check and output register.
//   Latency is one cycle; one coordinate accepted every cycle.
//
//   Ports:
//     clk, n_rst      clock, asynchronous active-low reset
//     valid           coordinate valid
//     x, y            pixel coordinate
//     idx             buffer index the address is generated for
//     addr            registered byte address (holds unless an in-range
//                     coordinate was accepted)
//     addr_valid      addr was updated by the previous cycle's coordinate
//     oob             previous cycle's coordinate was out of range (pulse)
// -----------------------------------------------------------------------------
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int unsigned       ADDR_W          = DEF_ADDR_W,
    parameter int unsigned       X_W             = DEF_X_W,
    parameter int unsigned       Y_W             = DEF_Y_W,
    parameter int unsigned       H_RES           = DEF_H_RES,
    parameter int unsigned       V_RES           = DEF_V_RES,
    parameter int unsigned       BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
    parameter int unsigned       LINE_STRIDE     = DEF_LINE_STRIDE,
    parameter logic [ADDR_W-1:0] BUF_STRIDE      = ADDR_W'(DEF_BUF_STRIDE),
    parameter logic [ADDR_W-1:0] BASE_ADDR       = ADDR_W'(DEF_BASE_ADDR)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              valid,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  buf_idx_t          idx,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              oob
);

    localparam logic [ADDR_W-1:0] LINE_STRIDE_W = ADDR_W'(LINE_STRIDE);
    localparam logic [ADDR_W-1:0] BPP_W         = ADDR_W'(BYTES_PER_PIXEL);
    // Limits carry one extra bit so a resolution equal to 2^X_W / 2^Y_W
    // still compares correctly.
    localparam logic [X_W:0]      H_LIM         = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]      V_LIM         = (Y_W+1)'(V_RES);

    logic              in_range;
    logic [ADDR_W-1:0] addr_next;

    // All terms are widened to ADDR_W first so the sum wraps modulo 2^ADDR_W.
    assign addr_next = BASE_ADDR
                     + ADDR_W'(idx) * BUF_STRIDE
                     + ADDR_W'(y)   * LINE_STRIDE_W
                     + ADDR_W'(x)   * BPP_W;

    assign in_range = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values of its neighbours, independent of process ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr       <= '0;
            addr_valid <= 1'b0;
            oob        <= 1'b0;
        end else begin
            addr_valid <= valid && in_range;
            oob        <= valid && !in_range;
            if (valid && in_range) begin
                addr <= addr_next;
            end
        end
    end

endmodule

// File: rtl/fb_addr_sequencer.sv
// -----------------------------------------------------------------------------
// fb_addr_sequencer
//   Multi-buffer frame-store address generator. Tracks the front (scanout)
//   and back (draw) buffers, defers flip requests to the next vsync, and
//   produces registered, range-checked byte addresses for a draw port (back
//   buffer) and a scanout port (front buffer).
//
//   Ports:
//     clk, n_rst                       clock, asynchronous active-low reset
//     flip_req                         request to present the back buffer
//     vsync                            frame-boundary strobe
//     wr_valid, wr_x, wr_y             draw coordinate
//     wr_addr, wr_addr_valid, wr_oob   draw address result
//     rd_valid, rd_x, rd_y             scanout coordinate
//     rd_addr, rd_addr_valid, rd_oob   scanout address result
//     front_idx, back_idx              current buffer indices
//     flip_pending                     flip accepted, waiting for vsync
//     flip_done                        pulse in the first cycle of new indices
// -----------------------------------------------------------------------------
module fb_addr_sequencer
    import fb_pkg::*;
#(
    parameter int unsigned       ADDR_W          = DEF_ADDR_W,
    parameter int unsigned       X_W             = DEF_X_W,
    parameter int unsigned       Y_W             = DEF_Y_W,
    parameter int unsigned       H_RES           = DEF_H_RES,
    parameter int unsigned       V_RES           = DEF_V_RES,
    parameter int unsigned       BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
    parameter int unsigned       LINE_STRIDE     = DEF_LINE_STRIDE,
    parameter logic [ADDR_W-1:0] BUF_STRIDE      = ADDR_W'(DEF_BUF_STRIDE),
    parameter logic [ADDR_W-1:0] BASE_ADDR       = ADDR_W'(DEF_BASE_ADDR),
    parameter int unsigned       NUM_BUFS        = DEF_NUM_BUFS
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flip_req,
    input  logic              vsync,
    input  logic              wr_valid,
    input  logic [X_W-1:0]    wr_x,
    input  logic [Y_W-1:0]    wr_y,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_addr_valid,
    output logic              wr_oob,
    input  logic              rd_valid,
    input  logic [X_W-1:0]    rd_x,
    input  logic [Y_W-1:0]    rd_y,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_addr_valid,
    output logic              rd_oob,
    output buf_idx_t          front_idx,
    output buf_idx_t          back_idx,
    output logic              flip_pending,
    output logic              flip_done
);

    flip_state_e state, state_next;
    logic        apply_flip;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            front_idx <= 2'd0;
            back_idx  <= 2'd1;
            flip_done <= 1'b0;
        end else begin
            state     <= state_next;
            flip_done <= apply_flip;
            if (apply_flip) begin
                front_idx <= back_idx;
                back_idx  <= next_buf(back_idx, NUM_BUFS);
            end
        end
    end

    // A request arriving together with vsync while idle is applied at once;
    // further requests while pending are absorbed.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned, which
        // would otherwise infer a latch.
        state_next = state;
        apply_flip = 1'b0;
        case (state)
            IDLE: begin
                if (flip_req) begin
                    if (vsync) begin
                        apply_flip = 1'b1;
                    end else begin
                        state_next = PENDING;
                    end
                end
            end
            PENDING: begin
                if (vsync) begin
                    apply_flip = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    assign flip_pending = (state == PENDING);

    fb_addr_calc #(
        .ADDR_W          (ADDR_W),
        .X_W             (X_W),
        .Y_W             (Y_W),
        .H_RES           (H_RES),
        .V_RES           (V_RES),
        .BYTES_PER_PIXEL (BYTES_PER_PIXEL),
        .LINE_STRIDE     (LINE_STRIDE),
        .BUF_STRIDE      (BUF_STRIDE),
        .BASE_ADDR       (BASE_ADDR)
    ) u_wr_calc (
        .clk        (clk),
        .n_rst      (n_rst),
        .valid      (wr_valid),
        .x          (wr_x),
        .y          (wr_y),
        .idx        (back_idx),
        .addr       (wr_addr),
        .addr_valid (wr_addr_valid),
        .oob        (wr_oob)
    );

    fb_addr_calc #(
        .ADDR_W          (ADDR_W),
        .X_W             (X_W),
        .Y_W             (Y_W),
        .H_RES           (H_RES),
        .V_RES           (V_RES),
        .BYTES_PER_PIXEL (BYTES_PER_PIXEL),
        .LINE_STRIDE     (LINE_STRIDE),
        .BUF_STRIDE      (BUF_STRIDE),
        .BASE_ADDR       (BASE_ADDR)
    ) u_rd_calc (
        .clk        (clk),
        .n_rst      (n_rst),
        .valid      (rd_valid),
        .x          (rd_x),
        .y          (rd_y),
        .idx        (front_idx),
        .addr       (rd_addr),
        .addr_valid (rd_addr_valid),
        .oob        (rd_oob)
    );

endmodule

// File: tb/tb_fb_addr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fb_addr_sequencer
//   Drives two instances (NUM_BUFS=2 and NUM_BUFS=3) with shared stimulus.
//   A behavioural model tracks the number of flips applied and computes the
//   expected indices and addresses arithmetically; a compare process checks
//   every output of both instances on each falling edge. Directed scenarios
//   add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_fb_addr_sequencer;

    localparam int NB [2] = '{2, 3};

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       flip_req = 1'b0;
    logic       vsync = 1'b0;
    logic       wr_valid = 1'b0;
    logic [8:0] wr_x = '0;
    logic [7:0] wr_y = '0;
    logic       rd_valid = 1'b0;
    logic [8:0] rd_x = '0;
    logic [7:0] rd_y = '0;

    logic [31:0] wr_addr_o [2];
    logic        wr_addr_valid_o [2];
    logic        wr_oob_o [2];
    logic [31:0] rd_addr_o [2];
    logic        rd_addr_valid_o [2];
    logic        rd_oob_o [2];
    logic [1:0]  front_o [2];
    logic [1:0]  back_o [2];
    logic        pending_o [2];
    logic        done_o [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    fb_addr_sequencer u_dut2 (
        .clk(clk), .n_rst(n_rst), .flip_req(flip_req), .vsync(vsync),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y),
        .wr_addr(wr_addr_o[0]), .wr_addr_valid(wr_addr_valid_o[0]), .wr_oob(wr_oob_o[0]),
        .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y),
        .rd_addr(rd_addr_o[0]), .rd_addr_valid(rd_addr_valid_o[0]), .rd_oob(rd_oob_o[0]),
        .front_idx(front_o[0]), .back_idx(back_o[0]),
        .flip_pending(pending_o[0]), .flip_done(done_o[0])
    );

    fb_addr_sequencer #(.NUM_BUFS(3)) u_dut3 (
        .clk(clk), .n_rst(n_rst), .flip_req(flip_req), .vsync(vsync),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y),
        .wr_addr(wr_addr_o[1]), .wr_addr_valid(wr_addr_valid_o[1]), .wr_oob(wr_oob_o[1]),
        .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y),
        .rd_addr(rd_addr_o[1]), .rd_addr_valid(rd_addr_valid_o[1]), .rd_oob(rd_oob_o[1]),
        .front_idx(front_o[1]), .back_idx(back_o[1]),
        .flip_pending(pending_o[1]), .flip_done(done_o[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // After k flips the front buffer is k mod N and the back is (k+1) mod N.
    int          flips [2];
    bit          m_pending;
    bit          m_done;
    logic [31:0] m_wr_addr [2];
    bit          m_wr_valid [2];
    bit          m_wr_oob [2];
    logic [31:0] m_rd_addr [2];
    bit          m_rd_valid [2];
    bit          m_rd_oob [2];

    function automatic logic [31:0] model_addr(input int idx, input int x, input int y);
        longint unsigned a;
        a = longint'(idx) * 64'h4B000 + longint'(y) * 1280 + longint'(x) * 4;
        return a[31:0];
    endfunction

    function automatic bit in_range(input int x, input int y);
        return (x < 320) && (y < 240);
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_pending <= 1'b0;
            m_done    <= 1'b0;
            for (int d = 0; d < 2; d++) begin
                flips[d]      <= 0;
                m_wr_addr[d]  <= '0;
                m_wr_valid[d] <= 1'b0;
                m_wr_oob[d]   <= 1'b0;
                m_rd_addr[d]  <= '0;
                m_rd_valid[d] <= 1'b0;
                m_rd_oob[d]   <= 1'b0;
            end
        end else begin
            m_done    <= vsync && (m_pending || flip_req);
            m_pending <= !vsync && (m_pending || flip_req);
            for (int d = 0; d < 2; d++) begin
                if (vsync && (m_pending || flip_req)) flips[d] <= flips[d] + 1;
                m_wr_valid[d] <= wr_valid && in_range(int'(wr_x), int'(wr_y));
                m_wr_oob[d]   <= wr_valid && !in_range(int'(wr_x), int'(wr_y));
                if (wr_valid && in_range(int'(wr_x), int'(wr_y)))
                    m_wr_addr[d] <= model_addr((flips[d] + 1) % NB[d], int'(wr_x), int'(wr_y));
                m_rd_valid[d] <= rd_valid && in_range(int'(rd_x), int'(rd_y));
                m_rd_oob[d]   <= rd_valid && !in_range(int'(rd_x), int'(rd_y));
                if (rd_valid && in_range(int'(rd_x), int'(rd_y)))
                    m_rd_addr[d] <= model_addr(flips[d] % NB[d], int'(rd_x), int'(rd_y));
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d front_idx", d), 64'(front_o[d]), 64'(flips[d] % NB[d]));
                check($sformatf("d%0d back_idx", d), 64'(back_o[d]), 64'((flips[d] + 1) % NB[d]));
                check($sformatf("d%0d flip_pending", d), 64'(pending_o[d]), 64'(m_pending));
                check($sformatf("d%0d flip_done", d), 64'(done_o[d]), 64'(m_done));
                check($sformatf("d%0d wr_addr_valid", d), 64'(wr_addr_valid_o[d]), 64'(m_wr_valid[d]));
                check($sformatf("d%0d wr_oob", d), 64'(wr_oob_o[d]), 64'(m_wr_oob[d]));
                check($sformatf("d%0d wr_addr", d), 64'(wr_addr_o[d]), 64'(m_wr_addr[d]));
                check($sformatf("d%0d rd_addr_valid", d), 64'(rd_addr_valid_o[d]), 64'(m_rd_valid[d]));
                check($sformatf("d%0d rd_oob", d), 64'(rd_oob_o[d]), 64'(m_rd_oob[d]));
                check($sformatf("d%0d rd_addr", d), 64'(rd_addr_o[d]), 64'(m_rd_addr[d]));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change just after a falling edge, are sampled on the next rising
    // edge, and the results are visible at the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic flip_pair(input logic [1:0] f2, input logic [1:0] b2,
                             input logic [1:0] f3, input logic [1:0] b3, input string tag);
        flip_req = 1'b1;
        vsync    = 1'b1;
        tick();
        flip_req = 1'b0;
        vsync    = 1'b0;
        check({tag, " flip_done"}, 64'(done_o[0]), 64'd1);
        check({tag, " flip_pending"}, 64'(pending_o[0]), 64'd0);
        check({tag, " n2 front"}, 64'(front_o[0]), 64'(f2));
        check({tag, " n2 back"}, 64'(back_o[0]), 64'(b2));
        check({tag, " n3 front"}, 64'(front_o[1]), 64'(f3));
        check({tag, " n3 back"}, 64'(back_o[1]), 64'(b3));
    endtask

    initial begin
        repeat (3) tick();
        cmp_en = 1'b1;
        check("reset front", 64'(front_o[0]), 64'd0);
        check("reset back", 64'(back_o[0]), 64'd1);
        check("reset wr_addr", 64'(wr_addr_o[0]), 64'd0);
        n_rst = 1'b1;
        tick();

        // Draw and scanout in the same cycle.
        wr_valid = 1'b1; wr_x = 9'd10;  wr_y = 8'd2;
        rd_valid = 1'b1; rd_x = 9'd319; rd_y = 8'd239;
        tick();
        wr_valid = 1'b0; rd_valid = 1'b0;
        check("draw wr_addr", 64'(wr_addr_o[0]), 64'h0004_BA28);
        check("draw wr_addr_valid", 64'(wr_addr_valid_o[0]), 64'd1);
        check("scan rd_addr", 64'(rd_addr_o[0]), 64'h0004_AFFC);
        tick();
        check("draw valid drops", 64'(wr_addr_valid_o[0]), 64'd0);

        // Deferred flip: request, wait 14 cycles, then vsync.
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        check("deferred pending rise", 64'(pending_o[0]), 64'd1);
        for (int i = 0; i < 14; i++) begin
            if (i == 6) flip_req = 1'b1;   // absorbed while pending
            tick();
            flip_req = 1'b0;
        end
        check("deferred still pending", 64'(pending_o[0]), 64'd1);
        check("deferred no early flip", 64'(front_o[0]), 64'd0);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("deferred flip_done", 64'(done_o[0]), 64'd1);
        check("deferred pending fall", 64'(pending_o[0]), 64'd0);
        check("deferred n2 front", 64'(front_o[0]), 64'd1);
        check("deferred n2 back", 64'(back_o[0]), 64'd0);
        check("deferred n3 front", 64'(front_o[1]), 64'd1);
        check("deferred n3 back", 64'(back_o[1]), 64'd2);
        tick();
        check("flip_done one cycle", 64'(done_o[0]), 64'd0);

        // Same-cycle request + vsync, then a third flip for the N=3 rotation.
        flip_pair(2'd0, 2'd1, 2'd2, 2'd0, "same-cycle");
        tick();
        flip_pair(2'd1, 2'd0, 2'd0, 2'd1, "third");
        tick();

        // Draw into back buffer (N=2 back is now 0), then out-of-range draws.
        wr_valid = 1'b1; wr_x = 9'd5; wr_y = 8'd1;
        tick();
        check("draw after flip", 64'(wr_addr_o[0]), 64'h0000_0514);
        wr_x = 9'd320; wr_y = 8'd0;
        tick();
        check("oob x wr_oob", 64'(wr_oob_o[0]), 64'd1);
        check("oob x valid", 64'(wr_addr_valid_o[0]), 64'd0);
        check("oob x addr hold", 64'(wr_addr_o[0]), 64'h0000_0514);
        wr_x = 9'd0; wr_y = 8'd240;
        tick();
        wr_valid = 1'b0;
        check("oob y wr_oob", 64'(wr_oob_o[0]), 64'd1);
        check("oob y addr hold", 64'(wr_addr_o[0]), 64'h0000_0514);
        tick();
        check("oob pulse ends", 64'(wr_oob_o[0]), 64'd0);

        // Reset discards a pending flip.
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        check("pre-reset pending", 64'(pending_o[0]), 64'd1);
        n_rst = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
        check("post-reset front", 64'(front_o[0]), 64'd0);
        check("post-reset back", 64'(back_o[0]), 64'd1);
        check("post-reset pending", 64'(pending_o[0]), 64'd0);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("vsync after reset no flip", 64'(done_o[0]), 64'd0);
        check("vsync after reset front", 64'(front_o[0]), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            flip_req = ($urandom_range(0, 7) == 0);
            vsync    = ($urandom_range(0, 15) == 0);
            wr_valid = $urandom_range(0, 1) == 1;
            wr_x     = 9'($urandom_range(0, 511));
            wr_y     = 8'($urandom_range(0, 255));
            rd_valid = $urandom_range(0, 1) == 1;
            rd_x     = 9'($urandom_range(0, 511));
            rd_y     = 8'($urandom_range(0, 255));
            n_rst    = ($urandom_range(0, 499) != 0);
            tick();
        end
        n_rst = 1'b1; flip_req = 1'b0; vsync = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        repeat (2) tick();
        cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_addr_sequencer.md
# fb_addr_sequencer

Parametrised multi-buffer frame-store address generator for the video path. Tracks which of NUM_BUFS frame buffers is being scanned out (front) and which is being drawn (back). Holds flip requests until the next frame boundary. Produces registered, range-checked byte addresses for one draw (write) port and one scanout (read) port. Sits between the pixel renderer / display controller and the memory interface.

## Interface
Parameters:
- ADDR_W, 32: address width
- X_W, 9: x coordinate width
- Y_W, 8: y coordinate width
- H_RES, 320: visible pixels per line
- V_RES, 240: visible lines
- BYTES_PER_PIXEL, 4: pixel size in bytes
- LINE_STRIDE, 1280: bytes per line
- BUF_STRIDE, 32'h0004_B000: bytes between buffer bases
- BASE_ADDR, 32'h0: byte address of buffer 0
- NUM_BUFS, 2: buffer count, legal 2..4

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- flip_req  in  1  single-cycle request to present the back buffer
- vsync  in  1  single-cycle frame-boundary strobe
- wr_valid  in  1  draw coordinate valid
- wr_x / wr_y  in  X_W / Y_W  draw coordinate
- wr_addr  out  ADDR_W  draw byte address
- wr_addr_valid  out  1  wr_addr valid
- wr_oob  out  1  draw coordinate out of range, 1-cycle pulse
- rd_valid, rd_x, rd_y, rd_addr, rd_addr_valid, rd_oob: same as the draw port, applied to the front buffer
- front_idx / back_idx  out  2  current buffer indices
- flip_pending  out  1  flip accepted, waiting for vsync
- flip_done  out  1  1-cycle pulse when the flip takes effect

## Operation
- Reset values:
  - front_idx=0, back_idx=1.
  - flip_pending=0.
  - All *_valid, *_oob and flip_done outputs 0.
  - wr_addr and rd_addr 0.
- Address:
  - Each port computes BASE_ADDR + idx*BUF_STRIDE + y*LINE_STRIDE + x*BYTES_PER_PIXEL.
  - Draw port uses back_idx; scanout port uses front_idx.
  - All arithmetic is ADDR_W wide, unsigned, and truncated modulo 2^ADDR_W.
- Range check:
  - A coordinate is in range when x<H_RES and y<V_RES.
  - valid with an in-range coordinate: addr_valid=1 next cycle.
  - valid with an out-of-range coordinate: addr_valid=0 and oob=1 next cycle; addr holds its previous value.
  - valid=0: addr_valid=0 and addr holds.
- Flip state machine (IDLE, PENDING):
  - IDLE + flip_req + !vsync → PENDING.
  - IDLE + flip_req + vsync → flip applied immediately, state stays IDLE.
  - PENDING + vsync → flip applied, state → IDLE.
  - flip_req while PENDING is absorbed: one flip only, no queueing.
  - vsync with no pending request: no effect.
- Applying a flip:
  - front_idx ← back_idx.
  - back_idx ← (back_idx+1) mod NUM_BUFS.
  - For NUM_BUFS=2 this swaps the two indices.
  - For NUM_BUFS>2 the buffers rotate round-robin; front never equals back.
- The two ports are independent and may both be valid in the same cycle.
- n_rst asserted mid-frame: all state returns to reset values immediately, any pending flip is discarded, and in-flight addresses are dropped.

## Timing
- Address latency is exactly 1 cycle: coordinate sampled at edge N, result visible after edge N.
- Fully pipelined: one coordinate per port per cycle.
- Indices update on the edge ending the cycle in which the flip applies.
  - A coordinate presented in that same cycle uses the old index.
  - flip_done is high for the following cycle, in which front_idx/back_idx show the new values.
- flip_pending rises in the cycle after an accepted flip_req. It falls in the same cycle flip_done rises.
- No combinational path from inputs to outputs.

## Structure
- Package fb_pkg holds:
  - default geometry and stride constants;
  - the flip state enum (IDLE, PENDING);
  - the buffer index type (2 bits).
- Sub-module fb_addr_calc: one coordinate-to-address path with range check and output register. Instantiated twice, one for draw and one for scanout, with idx as an input.
- The flip state machine and index registers live in the top level.

## Test plan
- Reset, then draw x=10,y=2 → wr_addr=0x0004_BA28 one cycle later, wr_addr_valid=1; scanout x=319,y=239 → rd_addr=0x0004_AFFC.
- flip_req at cycle 5, vsync at cycle 20 → flip_pending high cycles 6–20; flip_done at 21; front_idx=1, back_idx=0.
- flip_req and vsync in the same cycle, while IDLE → flip_done next cycle, flip_pending never rises.
- NUM_BUFS=3: three flip+vsync pairs → front sequence 1,2,0 and back sequence 2,0,1.
- Draw x=320,y=0, then x=0,y=240 → wr_oob pulses each time, wr_addr_valid=0, wr_addr unchanged.
- flip_req, then n_rst low for 2 cycles before vsync → indices 0/1, flip_pending=0, and a later vsync causes no flip.
